// File: rtl/gx_reconfig_pkg.sv
// Shared types and constants for the GX transceiver reconfiguration master.
package gx_reconfig_pkg;

    // Command opcode carried on cmd_op
    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RMW     = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    // Master FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // rsp_err bit positions and one-hot masks
    localparam int unsigned ERR_W       = 3;
    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_VERIFY  = 1;
    localparam int unsigned ERR_ILLEGAL = 2;

    localparam logic [ERR_W-1:0] ERR_M_TIMEOUT = ERR_W'(1 << ERR_TIMEOUT);
    localparam logic [ERR_W-1:0] ERR_M_VERIFY  = ERR_W'(1 << ERR_VERIFY);
    localparam logic [ERR_W-1:0] ERR_M_ILLEGAL = ERR_W'(1 << ERR_ILLEGAL);

endpackage

// File: rtl/gx_reconfig_if.sv
// Command/response and Avalon-MM reconfig bus bundle for gx_reconfig_master.
interface gx_reconfig_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    import gx_reconfig_pkg::*;

    // Local control side
    logic              cal_busy;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ERR_W-1:0]  rsp_err;

    // Transceiver reconfig slave side
    logic              reconfig_read;
    logic              reconfig_write;
    logic [ADDR_W-1:0] reconfig_address;
    logic [DATA_W-1:0] reconfig_writedata;
    logic [DATA_W-1:0] reconfig_readdata;
    logic              reconfig_waitrequest;

    modport master (
        input  cal_busy, cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        input  reconfig_readdata, reconfig_waitrequest,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output reconfig_read, reconfig_write, reconfig_address, reconfig_writedata
    );

    modport slave (
        output cal_busy, cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        output reconfig_readdata, reconfig_waitrequest,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  reconfig_read, reconfig_write, reconfig_address, reconfig_writedata
    );

endinterface

// File: rtl/gx_reconfig_wdog.sv
// Stall watchdog: counts consecutive strobe&waitrequest cycles, clears otherwise.
module gx_reconfig_wdog #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    input  logic wait_i,
    output logic expire_c_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic             stall_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign stall_c = strobe_i & wait_i;

    // Next count: advance while stalled, clear on completion or idle bus
    always_comb begin
        cnt_d = '0;
        if (stall_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the TIMEOUT_CYC-th stalled cycle so the strobe drops at that edge
    assign expire_c_o = stall_c & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/gx_reconfig_master.sv
// Avalon-MM initiator for the GX transceiver reconfig port: READ / WRITE / RMW
// commands with waitrequest handling and a stall watchdog.
// Optional build macro RECONFIG_READBACK_VERIFY_EN adds a readback-verify read
// after every WRITE/RMW and reports mismatches in rsp_err[1].
module gx_reconfig_master
    import gx_reconfig_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic          reconfig_clk,
    input  logic          reconfig_reset_n,
    gx_reconfig_if.master bus
);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] wdata_q;
    logic              read_q;
    logic              write_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ERR_W-1:0]  rsp_err_q;
    logic              accept_c;
    logic              wdog_expire_c;

    assign accept_c = bus.cmd_valid & bus.cmd_ready;

`ifdef RECONFIG_READBACK_VERIFY_EN
    logic [DATA_W-1:0] verify_mask_c;
    assign verify_mask_c = (op_q == OP_RMW) ? mask_q : '1;
`endif

    gx_reconfig_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk        (reconfig_clk),
        .rst_n      (reconfig_reset_n),
        .strobe_i   (read_q | write_q),
        .wait_i     (bus.reconfig_waitrequest),
        .expire_c_o (wdog_expire_c)
    );

    // Command sequencing, Avalon strobes and one-cycle response generation
    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_q   <= op_e'(bus.cmd_op);
                        addr_q <= bus.cmd_addr;
                        data_q <= bus.cmd_data;
                        mask_q <= bus.cmd_mask;
                        case (op_e'(bus.cmd_op))
                            OP_READ, OP_RMW: begin
                                state_q <= ST_READ;
                                read_q  <= 1'b1;
                            end
                            OP_WRITE: begin
                                state_q <= ST_WRITE;
                                write_q <= 1'b1;
                                wdata_q <= bus.cmd_data;
                            end
                            default: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= ERR_M_ILLEGAL;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    if (wdog_expire_c) begin
                        read_q      <= 1'b0;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_M_TIMEOUT;
                    end else if (!bus.reconfig_waitrequest) begin
                        read_q <= 1'b0;
                        if (op_q == OP_RMW) begin
                            state_q <= ST_WRITE;
                            write_q <= 1'b1;
                            wdata_q <= (bus.reconfig_readdata & ~mask_q) | (data_q & mask_q);
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= bus.reconfig_readdata;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wdog_expire_c) begin
                        write_q     <= 1'b0;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_M_TIMEOUT;
                    end else if (!bus.reconfig_waitrequest) begin
                        write_q <= 1'b0;
`ifdef RECONFIG_READBACK_VERIFY_EN
                        state_q <= ST_VERIFY;
                        read_q  <= 1'b1;
`else
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= wdata_q;
`endif
                    end
                end
`ifdef RECONFIG_READBACK_VERIFY_EN
                ST_VERIFY: begin
                    if (wdog_expire_c) begin
                        read_q      <= 1'b0;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_M_TIMEOUT;
                    end else if (!bus.reconfig_waitrequest) begin
                        read_q      <= 1'b0;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= wdata_q;
                        if (|((bus.reconfig_readdata ^ wdata_q) & verify_mask_c)) begin
                            rsp_err_q <= ERR_M_VERIFY;
                        end
                    end
                end
`endif
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready is gated by reset so it stays low while reset is asserted
    assign bus.cmd_ready          = reconfig_reset_n & (state_q == ST_IDLE) & ~bus.cal_busy;
    assign bus.rsp_valid          = rsp_valid_q;
    assign bus.rsp_data           = rsp_data_q;
    assign bus.rsp_err            = rsp_err_q;
    assign bus.reconfig_read      = read_q;
    assign bus.reconfig_write     = write_q;
    assign bus.reconfig_address   = addr_q;
    assign bus.reconfig_writedata = wdata_q;

endmodule

// File: tb/tb_gx_reconfig_master.sv
// Self-checking bench for gx_reconfig_master: vector table, corner sequences,
// and randomized commands against a memory-backed slave and reference model.
module tb_gx_reconfig_master;
    import gx_reconfig_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;
`ifdef RECONFIG_READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gx_reconfig_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    gx_reconfig_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .reconfig_clk     (clk),
        .reconfig_reset_n (rst_n),
        .bus              (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [0:1023];
    int      cur_waits;
    bit      stuck;
    bit      drop_writes;
    int      n_reads, n_writes, n_stall;
    logic [DW-1:0] last_wdata;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic [DW-1:0] pre;
        int            waits;
        logic [DW-1:0] exp_data;
        logic [2:0]    exp_err;
        int            lat_plain;
        int            lat_verify;
        logic [DW-1:0] exp_mem;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Avalon slave backed by mem; stalls cur_waits cycles per transfer, or forever when stuck
    task automatic slave_loop();
        int            wc = 0;
        bit            prev_stall = 1'b0;
        logic [AW-1:0] pa = '0;
        logic [DW-1:0] pd = '0;
        logic          pr = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.reconfig_read || bus.reconfig_write) begin
                chk("one_strobe", 32'(bus.reconfig_read & bus.reconfig_write), 32'd0);
                if (prev_stall) begin
                    chk("hold_addr", 32'(bus.reconfig_address), 32'(pa));
                    chk("hold_kind", 32'(bus.reconfig_read), 32'(pr));
                    if (bus.reconfig_write) chk("hold_wdata", bus.reconfig_writedata, pd);
                end
                pa = bus.reconfig_address;
                pd = bus.reconfig_writedata;
                pr = bus.reconfig_read;
                if (stuck || wc < cur_waits) begin
                    bus.reconfig_waitrequest = 1'b1;
                    bus.reconfig_readdata    = $urandom;
                    wc++;
                    n_stall++;
                    prev_stall = 1'b1;
                end else begin
                    bus.reconfig_waitrequest = 1'b0;
                    wc = 0;
                    prev_stall = 1'b0;
                    if (bus.reconfig_read) begin
                        bus.reconfig_readdata = mem[bus.reconfig_address];
                        n_reads++;
                    end else begin
                        bus.reconfig_readdata = $urandom;
                        last_wdata = bus.reconfig_writedata;
                        n_writes++;
                        if (!drop_writes) mem[bus.reconfig_address] = bus.reconfig_writedata;
                    end
                end
            end else begin
                bus.reconfig_waitrequest = 1'b0;
                bus.reconfig_readdata    = '0;
                wc = 0;
                prev_stall = 1'b0;
            end
        end
    endtask

    // Issue one command; returns response fields and latency from accept cycle (-1 if none)
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m, input int w, input bit busy_mid,
                           output logic [DW-1:0] rd, output logic [2:0] re, output int lat);
        int t0 = 0;
        bit acc = 1'b0;
        bit idle_bad = 1'b0;
        rd = '0; re = '0; lat = -1;
        @(negedge clk);
        cur_waits     = w;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_mask  = m;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            acc = bus.cmd_ready;
            t0  = cyc;
            @(negedge clk);
            if (acc) break;
        end
        bus.cmd_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        bus.cmd_op   = 2'($urandom);
        bus.cmd_addr = AW'($urandom);
        bus.cmd_data = $urandom;
        bus.cmd_mask = $urandom;
        bus.cal_busy = busy_mid;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid) begin
                rd  = bus.rsp_data;
                re  = bus.rsp_err;
                lat = cyc - t0;
                break;
            end
            if (bus.rsp_data !== '0 || bus.rsp_err !== '0) idle_bad = 1'b1;
            @(negedge clk);
        end
        bus.cal_busy = 1'b0;
        if (lat < 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            chk("rsp_idle_zero", 32'(idle_bad), 32'd0);
            @(negedge clk);
            chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    // Reference: transaction outcome from opcode rules, memory contents and wait count
    function automatic void model(input logic [1:0] op, input logic [DW-1:0] old, input logic [DW-1:0] d,
                                  input logic [DW-1:0] m, input int w, input bit drop,
                                  output logic [DW-1:0] ed, output logic [2:0] ee, output int lat,
                                  output int nr, output int nw, output logic [DW-1:0] emem);
        logic [DW-1:0] nv;
        logic [DW-1:0] vm;
        ed = '0; ee = 3'b000; lat = 1; nr = 0; nw = 0; emem = old;
        if (op == 2'b11) begin
            ee = 3'b100;
            return;
        end
        if (op == 2'b00) begin
            ed = old; lat = 2 + w; nr = 1;
            return;
        end
        nv   = (op == 2'b01) ? d : ((old & ~m) | (d & m));
        nr   = (op == 2'b10) ? 1 : 0;
        nw   = 1;
        lat  = (op == 2'b10) ? 3 + 2 * w : 2 + w;
        emem = drop ? old : nv;
        ed   = nv;
        if (VERIFY) begin
            nr  = nr + 1;
            lat = lat + 1 + w;
            vm  = (op == 2'b10) ? m : {DW{1'b1}};
            if (((emem ^ nv) & vm) != '0) ee = 3'b010;
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd, ed, emem, old;
        logic [2:0]    re, ee;
        int            lat, elat, enr, enw, r0, w0, s0, k;
        logic [1:0]    op;
        logic [AW-1:0] a;

        bus.cal_busy = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
        bus.cmd_addr = '0; bus.cmd_data = '0; bus.cmd_mask = '0;
        bus.reconfig_waitrequest = 1'b0; bus.reconfig_readdata = '0;
        cur_waits = 0; stuck = 1'b0; drop_writes = 1'b0;
        n_reads = 0; n_writes = 0; n_stall = 0; last_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        fork slave_loop(); join_none

        // Reset state, with a request already pending
        bus.cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_read", 32'(bus.reconfig_read), 32'd0);
        chk("rst_write", 32'(bus.reconfig_write), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_address", 32'(bus.reconfig_address), 32'd0);
        chk("rst_writedata", bus.reconfig_writedata, 32'd0);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

        // Vector table
        vt[0] = '{2'b00, 10'h0A6, 32'h0,        32'h0,        32'h12345678, 2, 32'h12345678, 3'b000, 4, 4, 32'h12345678};
        vt[1] = '{2'b10, 10'h007, 32'h00000050, 32'h000000F0, 32'hAAAAAAAA, 0, 32'hAAAAAA5A, 3'b000, 3, 4, 32'hAAAAAA5A};
        vt[2] = '{2'b01, 10'h3FF, 32'hDEADBEEF, 32'h0,        32'h0,        1, 32'hDEADBEEF, 3'b000, 3, 5, 32'hDEADBEEF};
        vt[3] = '{2'b11, 10'h055, 32'h11111111, 32'hFFFFFFFF, 32'h77777777, 0, 32'h0,        3'b100, 1, 1, 32'h77777777};
        vt[4] = '{2'b10, 10'h010, 32'hFFFFFFFF, 32'h0,        32'h0F0F0F0F, 1, 32'h0F0F0F0F, 3'b000, 5, 7, 32'h0F0F0F0F};
        vt[5] = '{2'b10, 10'h011, 32'h13579BDF, 32'hFFFFFFFF, 32'h2468ACE0, 0, 32'h13579BDF, 3'b000, 3, 4, 32'h13579BDF};
        vt[6] = '{2'b00, 10'h000, 32'h0,        32'h0,        32'hCAFEF00D, 3, 32'hCAFEF00D, 3'b000, 5, 5, 32'hCAFEF00D};
        for (int i = 0; i < 7; i++) begin
            mem[vt[i].addr] = vt[i].pre;
            r0 = n_reads; w0 = n_writes;
            run_cmd(vt[i].op, vt[i].addr, vt[i].data, vt[i].mask, vt[i].waits, 1'b0, rd, re, lat);
            chk($sformatf("vec%0d_data", i), rd, vt[i].exp_data);
            chk($sformatf("vec%0d_err", i), 32'(re), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(VERIFY ? vt[i].lat_verify : vt[i].lat_plain));
            chk($sformatf("vec%0d_mem", i), mem[vt[i].addr], vt[i].exp_mem);
            if (i == 1) chk("rmw_writedata", last_wdata, 32'hAAAAAA5A);
            if (i == 3) chk("illegal_no_bus", 32'((n_reads - r0) + (n_writes - w0)), 32'd0);
        end

        // Watchdog on a stuck READ: 16 stalled strobe cycles then err[0]
        stuck = 1'b1; s0 = n_stall;
        run_cmd(2'b00, 10'h0A6, '0, '0, 0, 1'b0, rd, re, lat);
        chk("to_read_err", 32'(re), 32'b001);
        chk("to_read_data", rd, 32'd0);
        chk("to_read_lat", 32'(lat), 32'd17);
        chk("to_read_strobe_cycles", 32'(n_stall - s0), 32'd16);
        chk("to_read_strobe_low", 32'(bus.reconfig_read), 32'd0);

        // Watchdog on a stuck WRITE: nothing committed
        mem[10'h030] = 32'h00005555; w0 = n_writes;
        run_cmd(2'b01, 10'h030, 32'h0000FFFF, '0, 0, 1'b0, rd, re, lat);
        chk("to_write_err", 32'(re), 32'b001);
        chk("to_write_lat", 32'(lat), 32'd17);
        chk("to_write_nocommit", 32'(n_writes - w0), 32'd0);
        stuck = 1'b0;

        // cal_busy blocks acceptance; release is accepted on the next edge
        @(negedge clk);
        mem[10'h021] = 32'h0BADCAFE;
        cur_waits = 0;
        bus.cal_busy = 1'b1; bus.cmd_op = 2'b00; bus.cmd_addr = 10'h021; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("busy_ready", 32'(bus.cmd_ready), 32'd0);
            chk("busy_no_strobe", 32'(bus.reconfig_read | bus.reconfig_write), 32'd0);
            @(negedge clk);
        end
        bus.cal_busy = 1'b0;
        #1 chk("busy_release_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("busy_accept_strobe", 32'(bus.reconfig_read), 32'd1);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin @(negedge clk); k++; end
        chk("busy_rsp_data", bus.rsp_data, 32'h0BADCAFE);
        @(negedge clk);

        // Readback verify: write that the slave silently drops
        mem[10'h020] = 32'h0; drop_writes = 1'b1; r0 = n_reads; w0 = n_writes;
        run_cmd(2'b01, 10'h020, 32'h00000001, '0, 0, 1'b0, rd, re, lat);
        drop_writes = 1'b0;
        chk("verify_err", 32'(re), VERIFY ? 32'b010 : 32'b000);
        chk("verify_data", rd, 32'h00000001);
        chk("verify_one_write", 32'(n_writes - w0), 32'd1);
        chk("verify_reads", 32'(n_reads - r0), VERIFY ? 32'd1 : 32'd0);

        // Reset in the middle of a stalled write
        stuck = 1'b1; mem[10'h040] = 32'h00001234; w0 = n_writes;
        @(negedge clk);
        bus.cmd_op = 2'b01; bus.cmd_addr = 10'h040; bus.cmd_data = 32'hFFFFFFFF; bus.cmd_valid = 1'b1;
        #1 chk("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("rstmid_write_high", 32'(bus.reconfig_write), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rstmid_write_async", 32'(bus.reconfig_write), 32'd0);
        stuck = 1'b0;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.reconfig_write) k++;
        end
        chk("rstmid_no_rsp", 32'(k), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_mem", mem[10'h040], 32'h00001234);
        chk("rstmid_no_commit", 32'(n_writes - w0), 32'd0);

        // Randomized commands against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [DW-1:0] d, m;
            int w;
            bit busy_mid;
            op = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
            a  = AW'($urandom % 16);
            d  = $urandom; m = $urandom;
            w  = int'($urandom % 4);
            busy_mid = 1'($urandom % 2);
            drop_writes = ($urandom % 6 == 0);
            old = mem[a]; r0 = n_reads; w0 = n_writes;
            model(op, old, d, m, w, drop_writes, ed, ee, elat, enr, enw, emem);
            run_cmd(op, a, d, m, w, busy_mid, rd, re, lat);
            drop_writes = 1'b0;
            chk($sformatf("rnd%0d_data", n), rd, ed);
            chk($sformatf("rnd%0d_err", n), 32'(re), 32'(ee));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_mem", n), mem[a], emem);
            chk($sformatf("rnd%0d_reads", n), 32'(n_reads - r0), 32'(enr));
            chk($sformatf("rnd%0d_writes", n), 32'(n_writes - w0), 32'(enw));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
